// File: rtl/fir_bank_pkg.sv
// Shared definitions for the FIR bank engine: FSM encoding, width helper and
// the output round/saturate function.
package fir_bank_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_MAC   = 2'd2;
  localparam logic [1:0] ST_ROUND = 2'd3;

  // Coefficient ROM address width (one word per tap pair).
  function automatic int addr_w(input int ntaps);
    return (ntaps > 2) ? $clog2(ntaps / 2) : 1;
  endfunction

  // Round half up, arithmetic shift, clamp to a dw-bit signed range.
  // Works in 64 bits, so accumulators up to 63 bits are supported.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int oshift,
                                                   input int dw);
    logic signed [63:0] rnd;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd = (oshift > 0) ? (64'sd1 <<< (oshift - 1)) : 64'sd0;
    r   = (acc + rnd) >>> oshift;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    if (r > hi)
      r = hi;
    else if (r < lo)
      r = lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_bank_engine_if.sv
// Sample, coefficient-ROM and result signals of the FIR bank engine.
interface fir_bank_engine_if #(
  parameter int NFILT = 8,
  parameter int NTAPS = 128,
  parameter int DW    = 16,
  parameter int CW    = 18
);
  import fir_bank_pkg::*;

  localparam int AW = addr_w(NTAPS);

  logic signed [DW-1:0]       datain;
  logic                       din_enable;
  logic [AW-1:0]              coeffaddress;
  logic [NFILT*2*CW-1:0]      coeffs;
  logic [NFILT*DW-1:0]        dataout;
  logic                       dout_valid;
  logic                       busy;
  logic                       overrun;

  modport master (
    output datain, din_enable, coeffs,
    input  coeffaddress, dataout, dout_valid, busy, overrun
  );

  modport slave (
    input  datain, din_enable, coeffs,
    output coeffaddress, dataout, dout_valid, busy, overrun
  );

endinterface

// File: rtl/fir_hist_buf.sv
// Circular sample history: one write port, two combinational read ports
// addressed by distance behind the newest sample.
module fir_hist_buf #(
  parameter int NTAPS = 128,
  parameter int DW    = 16,
  localparam int HW   = $clog2(NTAPS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic signed [DW-1:0] wr_data,
  input  logic [HW-1:0]        rd_off0,
  input  logic [HW-1:0]        rd_off1,
  output logic signed [DW-1:0] rd_data0,
  output logic signed [DW-1:0] rd_data1
);

  localparam int TW = HW + 1;

  logic signed [DW-1:0] mem [NTAPS];
  logic [HW-1:0]        wptr;

  // wptr points at the next free slot, so newest sample is at wptr-1.
  function automatic logic [HW-1:0] idx_of(input logic [HW-1:0] wp,
                                           input logic [HW-1:0] off);
    logic [TW-1:0] t;
    t = {1'b0, wp} + TW'(NTAPS - 1) - {1'b0, off};
    if (t >= TW'(NTAPS))
      t = t - TW'(NTAPS);
    return HW'(t);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      for (int i = 0; i < NTAPS; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[wptr] <= wr_data;
      wptr      <= (wptr == HW'(NTAPS - 1)) ? '0 : wptr + HW'(1);
    end
  end

  assign rd_data0 = mem[idx_of(wptr, rd_off0)];
  assign rd_data1 = mem[idx_of(wptr, rd_off1)];

endmodule

// File: rtl/fir_bank_engine.sv
// NFILT parallel FIR filters over one shared history, two taps per filter per
// cycle, with rounded/saturated registered outputs.
//
//  state    | meaning
//  ---------+--------------------------------------------------------
//  ST_IDLE  | waiting for din_enable; accept writes history, clears acc
//  ST_FETCH | one cycle for the ROM read latency
//  ST_MAC   | NTAPS/2 cycles, one coefficient pair per cycle
//  ST_ROUND | round/saturate accumulators into dataout
module fir_bank_engine
  import fir_bank_pkg::*;
#(
  parameter int NFILT  = 8,
  parameter int NTAPS  = 128,
  parameter int DW     = 16,
  parameter int CW     = 18,
  parameter int ACCW   = 42,
  parameter int OSHIFT = 16
) (
  input logic              clock,
  input logic              reset,
  fir_bank_engine_if.slave bus
);

  localparam int            AW    = addr_w(NTAPS);
  localparam int            NPAIR = NTAPS / 2;
  localparam logic [AW-1:0] LAST  = AW'(NPAIR - 1);

  logic [1:0]           state;
  logic [AW-1:0]        addr;
  logic [AW-1:0]        pair;
  logic                 dv;
  logic                 ovr;
  logic                 accept;
  logic signed [DW-1:0] x_even;
  logic signed [DW-1:0] x_odd;
  logic [NFILT*DW-1:0]  dout_flat;

  assign accept = (state == ST_IDLE) && bus.din_enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      addr  <= '0;
      pair  <= '0;
      dv    <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      dv <= 1'b0;
      if (bus.din_enable && (state != ST_IDLE))
        ovr <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.din_enable) begin
            state <= ST_FETCH;
            addr  <= '0;
          end
        end
        ST_FETCH: begin
          state <= ST_MAC;
          addr  <= AW'(1);
          pair  <= '0;
        end
        ST_MAC: begin
          // Address runs one pair ahead of the MAC and parks on the last word.
          if (addr != LAST)
            addr <= addr + AW'(1);
          if (pair == LAST)
            state <= ST_ROUND;
          else
            pair <= pair + AW'(1);
        end
        ST_ROUND: begin
          dv    <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fir_hist_buf #(.NTAPS(NTAPS), .DW(DW)) u_hist (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (accept),
    .wr_data  (bus.datain),
    .rd_off0  ({pair, 1'b0}),
    .rd_off1  ({pair, 1'b1}),
    .rd_data0 (x_even),
    .rd_data1 (x_odd)
  );

  for (genvar f = 0; f < NFILT; f++) begin : g_lane
    logic signed [CW-1:0]    c_even;
    logic signed [CW-1:0]    c_odd;
    logic signed [DW+CW-1:0] p_even;
    logic signed [DW+CW-1:0] p_odd;
    logic signed [ACCW-1:0]  acc;
    logic [DW-1:0]           dout_q;

    assign c_even = bus.coeffs[f*2*CW +: CW];
    assign c_odd  = bus.coeffs[f*2*CW+CW +: CW];
    assign p_even = c_even * x_even;
    assign p_odd  = c_odd * x_odd;

    always_ff @(posedge clock) begin
      if (reset) begin
        acc    <= '0;
        dout_q <= '0;
      end else begin
        if (accept)
          acc <= '0;
        else if (state == ST_MAC)
          acc <= acc + ACCW'(p_even) + ACCW'(p_odd);
        if (state == ST_ROUND)
          dout_q <= DW'(round_sat(64'(acc), OSHIFT, DW));
      end
    end

    assign dout_flat[f*DW +: DW] = dout_q;
  end

  assign bus.coeffaddress = addr;
  assign bus.dataout      = dout_flat;
  assign bus.dout_valid   = dv;
  assign bus.busy         = (state != ST_IDLE) || dv;
  assign bus.overrun      = ovr;

endmodule
